segment_7_to_bcd_rx: RTL and testbench

SEGMENT_7_TO_BCD_RX -- requirements
Module: segment_7_to_bcd_rx

---
 rtl/segment_7_to_bcd_rx.sv | 163 ++++++++++++++++
 tb/tb_segment_7_to_bcd_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/segment_7_to_bcd_rx.sv
// Seven-segment receiver: synchronizes seg_in, debounces it and reports each new stable digit once.
// Latency: digit_valid rises on the (STABLE_CYCLES+3)th clk edge after seg_in settles (FSM in IDLE).
// Backpressure: a result is held unchanged until digit_ready; the filter keeps running meanwhile.
//
// Ports:
//   clk, rst_n        - single clock, asynchronous active-low reset
//   seg_in[6:0]       - asynchronous segment lines, bit6=a .. bit0=g, active high
//   digit_ready       - consumer accept strobe
//   digit_valid       - digit/digit_illegal hold a captured result
//   digit[3:0]        - BCD 0..9, or 4'hF for an illegal pattern
//   digit_illegal     - captured pattern is nonzero and not a decimal digit
//   err_count[7:0]    - saturating count of illegal reports (only with SEG_RX_ERR_CNT_EN)
// Optional feature macro: SEG_RX_ERR_CNT_EN
module segment_7_to_bcd_rx #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       digit_ready,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic       digit_illegal
`ifdef SEG_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;
    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

    // Returns {illegal, bcd}; blank decodes to zero but is never reported.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b0000000: r = 5'h00;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    logic [6:0] sync1_q, sync2_q;
    logic [6:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] last_q, last_d;
    logic [0:0] state_q, state_d;
    logic       valid_q, valid_d;
    logic [3:0] digit_q, digit_d;
    logic       illegal_q, illegal_d;
    logic [6:0] sample;
    logic [4:0] dec;
    logic       accept;
    logic       blank_stable;

    assign sample = sync2_q;
    assign dec    = decode(cand_q);

    // A new report needs a fully settled candidate that differs from the last report.
    assign accept = (state_q == ST_IDLE) && (cnt_q == STABLE_MAX) && (sample == cand_q)
                    && (cand_q != last_q) && (cand_q != 7'd0);
    // A settled blank re-arms reporting so the same digit can be shown again.
    assign blank_stable = (cnt_q == STABLE_MAX) && (cand_q == 7'd0);

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        state_d   = state_q;
        valid_d   = valid_q;
        digit_d   = digit_q;
        illegal_d = illegal_q;

        // Stability filter runs in every state.
        if (sample != cand_q) begin
            cand_d = sample;
            cnt_d  = 4'd1;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_PRESENT;
                    valid_d   = 1'b1;
                    digit_d   = dec[3:0];
                    illegal_d = dec[4];
                    last_d    = cand_q;
                end else if (blank_stable) begin
                    last_d = 7'd0;
                end
            end
            default: begin
                if (digit_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 7'd0;
            sync2_q   <= 7'd0;
            cand_q    <= 7'd0;
            cnt_q     <= 4'd0;
            last_q    <= 7'd0;
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            digit_q   <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            sync1_q   <= seg_in;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            digit_q   <= digit_d;
            illegal_q <= illegal_d;
        end
    end

    assign digit_valid   = valid_q;
    assign digit         = digit_q;
    assign digit_illegal = illegal_q;

`ifdef SEG_RX_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && dec[4] && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_segment_7_to_bcd_rx.sv
// Directed bench for segment_7_to_bcd_rx with a report scoreboard.
// Expected reports are queued when a pattern is driven and popped on each valid/ready handshake.
// Latency and hold behaviour are checked inline after each clock edge.
module tb_segment_7_to_bcd_rx;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       digit_ready;
    logic       digit_valid;
    logic [3:0] digit;
    logic       digit_illegal;
`ifdef SEG_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [4:0] sb[$];

    segment_7_to_bcd_rx #(.STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_in        (seg_in),
        .digit_ready   (digit_ready),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .digit_illegal (digit_illegal)
`ifdef SEG_RX_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Seg_in was changed just after an edge; valid must stay low for 6 edges and rise on the 7th.
    task automatic expect_latency(input string tag, input logic [3:0] d, input logic il);
        logic early;
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (digit_valid) early = 1'b1;
        end
        chk({tag, "_early"}, 32'(early), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(digit_valid), 32'd1);
        chk({tag, "_dig"}, 32'(digit), 32'(d));
        chk({tag, "_ill"}, 32'(digit_illegal), 32'(il));
    endtask

    // Scoreboard consumer: one pop per accepted result.
    always @(negedge clk) begin
        if (rst_n && digit_valid && digit_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_report: observed digit %0h ill %0b, expected no report", digit, digit_illegal);
            end
            if (sb.size() > 0) begin
                logic [4:0] e;
                e = sb.pop_front();
                checks++;
                assert ({digit_illegal, digit} === e) else begin
                    errors++;
                    $error("FAIL report: observed %0h expected %0h", {digit_illegal, digit}, e);
                end
            end
        end
    end

    initial begin
        logic held;
        rst_n       = 1'b0;
        seg_in      = 7'd0;
        digit_ready = 1'b0;
        #1;
        chk("rst_vld", 32'(digit_valid), 32'd0);
        chk("rst_dig", 32'(digit), 32'd0);
        chk("rst_ill", 32'(digit_illegal), 32'd0);
`ifdef SEG_RX_ERR_CNT_EN
        chk("rst_err", 32'(err_count), 32'd0);
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Digit 5 held without ready: stays presented until accepted.
        seg_in = 7'b1011011;
        sb.push_back(5'h05);
        expect_latency("d5", 4'd5, 1'b0);
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!digit_valid || digit !== 4'd5) held = 1'b0;
        end
        chk("d5_hold", 32'(held), 32'd1);
        digit_ready = 1'b1;
        tick();
        chk("d5_ack_vld", 32'(digit_valid), 32'd0);
        chk("d5_retain", 32'(digit), 32'd5);

        // Digit 3 with ready held: exactly one report while held.
        seg_in = 7'b1111001;
        sb.push_back(5'h03);
        expect_latency("d3", 4'd3, 1'b0);
        tick();
        chk("d3_one_cycle", 32'(digit_valid), 32'd0);
        repeat (20) tick();
        chk("d3_sb_empty", 32'(sb.size()), 32'd0);

        // 1 / blank / 1 gives two reports.
        seg_in = 7'b0110000;
        sb.push_back(5'h01);
        sb.push_back(5'h01);
        repeat (10) tick();
        chk("d1_first", 32'(sb.size()), 32'd1);
        seg_in = 7'b0000000;
        repeat (10) tick();
        seg_in = 7'b0110000;
        repeat (10) tick();
        chk("d1_twice", 32'(sb.size()), 32'd0);

        // Glitch to 8 mid-count: only 0 reported, latency measured from glitch end.
        seg_in = 7'b1111110;
        held = 1'b0;
        repeat (3) begin tick(); if (digit_valid) held = 1'b1; end
        seg_in = 7'b1111111;
        repeat (2) begin tick(); if (digit_valid) held = 1'b1; end
        chk("glitch_quiet", 32'(held), 32'd0);
        seg_in = 7'b1111110;
        sb.push_back(5'h00);
        expect_latency("d0", 4'd0, 1'b0);
        repeat (5) tick();
        chk("d0_sb_empty", 32'(sb.size()), 32'd0);

        // Illegal pattern and error counter saturation.
`ifdef SEG_RX_ERR_CNT_EN
        chk("err_before", 32'(err_count), 32'd0);
`endif
        seg_in = 7'b1000001;
        sb.push_back(5'h1F);
        expect_latency("ill", 4'hF, 1'b1);
`ifdef SEG_RX_ERR_CNT_EN
        chk("err_one", 32'(err_count), 32'd1);
`endif
        repeat (3) tick();
        seg_in = 7'd0;
        repeat (9) tick();
        for (int p = 0; p < 300; p++) begin
            seg_in = (p % 2 == 0) ? 7'b0000001 : 7'b1000001;
            sb.push_back(5'h1F);
            repeat (9) tick();
            seg_in = 7'd0;
            repeat (9) tick();
        end
        chk("ill_sb_empty", 32'(sb.size()), 32'd0);
`ifdef SEG_RX_ERR_CNT_EN
        chk("err_sat", 32'(err_count), 32'd255);
`endif

        // Pattern settling during PRESENT is reported right after the handshake.
        digit_ready = 1'b0;
        seg_in = 7'b0110011;
        sb.push_back(5'h04);
        expect_latency("d4", 4'd4, 1'b0);
        seg_in = 7'b1011111;
        sb.push_back(5'h06);
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!digit_valid || digit !== 4'd4) held = 1'b0;
        end
        chk("d4_frozen", 32'(held), 32'd1);
        digit_ready = 1'b1;
        tick();
        chk("d4_ack", 32'(digit_valid), 32'd0);
        tick();
        chk("d6_next_vld", 32'(digit_valid), 32'd1);
        chk("d6_next_dig", 32'(digit), 32'd6);
        tick();

        // Reset in PRESENT with 7 shown and 8 pending.
        digit_ready = 1'b0;
        seg_in = 7'b1110000;
        sb.push_back(5'h07);
        expect_latency("d7", 4'd7, 1'b0);
        seg_in = 7'b1111111;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!digit_valid || digit !== 4'd7) held = 1'b0;
        end
        chk("d7_frozen", 32'(held), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(digit_valid), 32'd0);
        chk("mid_rst_dig", 32'(digit), 32'd0);
        chk("mid_rst_ill", 32'(digit_illegal), 32'd0);
`ifdef SEG_RX_ERR_CNT_EN
        chk("mid_rst_err", 32'(err_count), 32'd0);
`endif
        sb.delete();
        tick();
        rst_n = 1'b1;
        digit_ready = 1'b1;
        sb.push_back(5'h08);
        expect_latency("d8", 4'd8, 1'b0);
        repeat (20) tick();
        chk("d8_once", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
